// File: rtl/remote_comm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : remote_comm_pkg
// Purpose  : Shared types and constants for the remote_comm command sender.
// Revision : 1.0 - initial release
// ============================================================================
package remote_comm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TX_HI     = 2'd1,
        TX_LO     = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_PROG  = 8'h5A;
    localparam int         FRAME_BITS = 10;

endpackage
`default_nettype wire

// File: rtl/uart_trcv.sv
`default_nettype none
// ============================================================================
// Module   : uart_trcv
// Purpose  : 8N1 UART transmitter and receiver sharing one bit period.
// Revision : 1.0 - initial release
// ============================================================================
module uart_trcv
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy
);

    localparam int                  c_cnt_w     = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(BAUD_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [3:0]         c_stop_idx  = 4'(FRAME_BITS - 1);

    logic               r_tx;
    logic               r_tx_act;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [3:0]         r_tx_bit;
    logic [7:0]         r_tx_shift;

    logic               r_rx_s1;
    logic               r_rx_s2;
    logic               r_rx_prev;
    logic               r_rx_act;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [3:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_rdy;

    assign tx      = r_tx;
    assign tx_done = r_tx_act && (r_tx_bit == c_stop_idx) && (r_tx_cnt == c_bit_last);
    assign rx_data = r_rx_data;
    assign rx_rdy  = r_rx_rdy;

    // tx_data is captured at the end of the start bit, so the caller only
    // needs it stable from trmt until then; a trmt on the final stop-bit cycle
    // chains the next frame with no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_tx_act   <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else if (trmt) begin
            r_tx     <= 1'b0;
            r_tx_act <= 1'b1;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
        end else if (r_tx_act) begin
            if (r_tx_cnt == c_bit_last) begin
                r_tx_cnt <= '0;
                r_tx_bit <= r_tx_bit + 4'd1;
                if (r_tx_bit == c_stop_idx) begin
                    r_tx     <= 1'b1;
                    r_tx_act <= 1'b0;
                end else if (r_tx_bit == 4'd0) begin
                    r_tx       <= tx_data[0];
                    r_tx_shift <= {1'b1, tx_data[7:1]};
                end else begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + c_cnt_one;
            end
        end
    end

    // A new start needs a synchronized 1->0 edge, so after a framing error
    // the receiver naturally waits for the line to return high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_act   <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_rdy  <= 1'b0;
            if (!r_rx_act) begin
                if (r_rx_prev && !r_rx_s2) begin
                    r_rx_act <= 1'b1;
                    r_rx_cnt <= c_half_last;
                    r_rx_bit <= '0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - c_cnt_one;
            end else begin
                r_rx_cnt <= c_bit_last;
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_s2) begin
                        r_rx_act <= 1'b0;
                    end
                end else if (r_rx_bit == c_stop_idx) begin
                    r_rx_act <= 1'b0;
                    if (r_rx_s2) begin
                        r_rx_data <= r_rx_shift;
                        r_rx_rdy  <= 1'b1;
                    end
                end else begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/remote_comm.sv
`default_nettype none
// ============================================================================
// Module   : remote_comm
// Purpose  : Sends a 16-bit command as two UART bytes and tracks the robot's
//            progress/done responses. Define REMOTE_COMM_TIMEOUT_EN to build
//            the response-wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV    = 5208,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    input  logic        RX,
    output logic        busy,
    output logic        cmd_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        timeout
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cmd;
    logic        r_cmd_snt;
    logic        r_timeout;
    logic        w_trmt;
    logic [7:0]  w_tx_data;
    logic        w_tx_done;
    logic        w_rx_rdy;
    logic [7:0]  w_rx_data;
    logic        w_to_hit;
    logic        w_to_fire;

    // Out-of-range parameters leave this marker scope in the elaborated tree.
    if (BAUD_DIV < 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << 26)) begin : g_param_range_illegal
    end

    assign w_tx_data = (r_state == TX_LO) ? r_cmd[7:0] : r_cmd[15:8];

    uart_trcv #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk     (clk),
        .rst     (rst),
        .trmt    (w_trmt),
        .tx_data (w_tx_data),
        .tx      (TX),
        .tx_done (w_tx_done),
        .rx      (RX),
        .rx_data (w_rx_data),
        .rx_rdy  (w_rx_rdy)
    );

`ifdef REMOTE_COMM_TIMEOUT_EN
    localparam logic [25:0] c_to_last = 26'(TIMEOUT_CYC - 1);
    logic [25:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != WAIT_RESP || w_rx_rdy) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 26'd1;
        end
    end

    assign w_to_hit = (r_state == WAIT_RESP) && (r_to_cnt == c_to_last);
`else
    assign w_to_hit = 1'b0;
`endif

    // A byte reported in the WAIT_RESP entry cycle was sampled before the
    // command finished, so it is treated like a byte seen while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_trmt      = 1'b0;
        w_to_fire   = 1'b0;
        case (r_state)
            IDLE: begin
                if (snd_cmd) begin
                    w_trmt      = 1'b1;
                    w_state_nxt = TX_HI;
                end
            end
            TX_HI: begin
                if (w_tx_done) begin
                    w_trmt      = 1'b1;
                    w_state_nxt = TX_LO;
                end
            end
            TX_LO: begin
                if (w_tx_done) begin
                    w_state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (w_rx_rdy && !r_cmd_snt) begin
                    case (w_rx_data)
                        RESP_PROG: w_state_nxt = WAIT_RESP;
                        RESP_DONE: w_state_nxt = IDLE;
                        default:   w_state_nxt = IDLE;
                    endcase
                end else if (w_to_hit) begin
                    w_to_fire   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cmd     <= '0;
            r_cmd_snt <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_snt <= (r_state == TX_LO) && w_tx_done;
            r_timeout <= w_to_fire;
            if (r_state == IDLE && snd_cmd) begin
                r_cmd <= cmd;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign cmd_snt  = r_cmd_snt;
    assign timeout  = r_timeout;
    assign resp     = w_rx_data;
    assign resp_rdy = w_rx_rdy;

endmodule
`default_nettype wire

// File: tb/tb_remote_comm.sv
`default_nettype none
// ============================================================================
// Module   : tb_remote_comm
// Purpose  : Self-checking bench for remote_comm with a UART-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_remote_comm;

    localparam int BD = 16;
    localparam int TO = 1000;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] cmd     = '0;
    logic        snd_cmd = 1'b0;
    logic        RX      = 1'b1;
    logic        TX;
    logic        busy;
    logic        cmd_snt;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        timeout;

    remote_comm #(
        .BAUD_DIV    (BD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .TX       (TX),
        .RX       (RX),
        .busy     (busy),
        .cmd_snt  (cmd_snt),
        .resp     (resp),
        .resp_rdy (resp_rdy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_cyc_q[$];
    int rdy_val_q[$];
    int to_cyc_q[$];
    logic [7:0] exp_resp = 8'h00;

    always @(negedge clk) begin
        if (resp_rdy) begin
            rdy_cyc_q.push_back(cyc);
            rdy_val_q.push_back(int'(resp));
        end
        if (timeout) to_cyc_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line: two 8N1 frames back to back, high byte first, LSB first.
    task automatic send_cmd(input logic [15:0] c, input bit repulse, output int snt_cyc);
        logic [19:0] bits;
        bits = {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
        check_eq("idle_before_cmd", busy, 0);
        cmd     = c;
        snd_cmd = 1'b1;
        tick;
        snd_cmd = 1'b0;
        cmd     = 16'($urandom);
        check_eq("busy_after_accept", busy, 1);
        check_eq("tx_start_edge", TX, 0);
        for (int t = 0; t < 20 * BD; t++) begin
            if (t % BD == BD / 2) begin
                check_eq($sformatf("tx_bit%0d", t / BD), TX, bits[t / BD]);
                check_eq("busy_during_tx", busy, 1);
                check_eq("no_early_cmd_snt", cmd_snt, 0);
            end
            if (repulse && t == 49) begin
                snd_cmd = 1'b1;
                cmd     = ~c;
            end else begin
                snd_cmd = 1'b0;
            end
            tick;
        end
        snd_cmd = 1'b0;
        snt_cyc = cyc;
        check_eq("cmd_snt_pulse", cmd_snt, 1);
        check_eq("tx_idle_after_frames", TX, 1);
        check_eq("busy_in_wait", busy, 1);
        tick;
        check_eq("cmd_snt_one_cycle", cmd_snt, 0);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop, output int t0);
        RX = 1'b0;
        t0 = cyc;
        repeat (BD) tick;
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (BD) tick;
        end
        RX = stop;
        repeat (BD) tick;
        RX = 1'b1;
    endtask

    task automatic rx_byte(input logic [7:0] d, input bit stop_ok, input bit exp_busy);
        int t0;
        repeat ($urandom_range(2, 20)) tick;
        rdy_cyc_q.delete();
        rdy_val_q.delete();
        send_rx(d, stop_ok, t0);
        if (stop_ok) begin
            exp_resp = d;
            check_eq("rdy_count", rdy_cyc_q.size(), 1);
            if (rdy_cyc_q.size() > 0) begin
                check_eq("rdy_latency", rdy_cyc_q[0] - t0, 2 + BD / 2 + 9 * BD + 1);
                check_eq("rdy_value", rdy_val_q[0], int'(d));
            end
        end else begin
            check_eq("frame_err_no_rdy", rdy_cyc_q.size(), 0);
        end
        check_eq("resp_value", resp, exp_resp);
        check_eq("busy_after_byte", busy, exp_busy);
    endtask

    // Model of a tour: some progress bytes, maybe a corrupted frame, then an exit byte.
    task automatic respond_seq;
        int         n_prog;
        logic [7:0] fin;
        n_prog = $urandom_range(0, 3);
        for (int i = 0; i < n_prog; i++) rx_byte(8'h5A, 1'b1, 1'b1);
        if ($urandom_range(0, 2) == 0) rx_byte(8'($urandom), 1'b0, 1'b1);
        if ($urandom_range(0, 3) != 0) begin
            fin = 8'hA5;
        end else begin
            fin = 8'($urandom);
            if (fin == 8'h5A) fin = 8'h00;
        end
        rx_byte(fin, 1'b1, 1'b0);
    endtask

    initial begin
        int         snt;
        logic [15:0] c;

        repeat (3) tick;
        check_eq("rst_tx", TX, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd_snt", cmd_snt, 0);
        check_eq("rst_resp", resp, 0);
        check_eq("rst_resp_rdy", resp_rdy, 0);
        check_eq("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick;

        send_cmd(16'h2C35, 1'b1, snt);
        for (int i = 0; i < 3; i++) rx_byte(8'h5A, 1'b1, 1'b1);
        rx_byte(8'hA5, 1'b1, 1'b0);

        send_cmd(16'($urandom), 1'b0, snt);
        rx_byte(8'h77, 1'b0, 1'b1);
        rx_byte(8'hA5, 1'b1, 1'b0);

        rx_byte(8'h3C, 1'b1, 1'b0);

`ifdef REMOTE_COMM_TIMEOUT_EN
        send_cmd(16'($urandom), 1'b0, snt);
        for (int k = 0; k < TO + 100 && !timeout; k++) tick;
        check_eq("timeout_seen", timeout, 1);
        check_eq("timeout_delay", cyc - snt, TO);
        check_eq("busy_after_timeout", busy, 0);
        tick;
        check_eq("timeout_one_cycle", timeout, 0);
`endif

        c       = 16'($urandom);
        cmd     = c;
        snd_cmd = 1'b1;
        tick;
        snd_cmd = 1'b0;
        repeat (5 * BD + 3) tick;
        check_eq("tx_hi_bit4", TX, c[12]);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_resp = 8'h00;
        check_eq("midrst_tx", TX, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_cmd_snt", cmd_snt, 0);
        check_eq("midrst_resp", resp, 0);
        tick;
        send_cmd(16'($urandom), 1'b0, snt);
        respond_seq();

        for (int i = 0; i < 6; i++) begin
            send_cmd(16'($urandom), 1'($urandom_range(0, 1)), snt);
            respond_seq();
        end

`ifndef REMOTE_COMM_TIMEOUT_EN
        check_eq("timeout_tied_low", to_cyc_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
